// File: rtl/bounce_monitor.sv
// ----------------------------------------------------------------------------
// bounce_monitor
//
// Watches the position/velocity stream of the bouncing-ball physics core (one
// sample per Sample_Valid strobe) and reconstructs flight events from it:
// floor bounces, apex crossings, peak height and duration of the last
// completed flight, and a resting flag once the ball only makes short hops.
// All data is signed q8.24.
//
// Ports
//   CLOCK_50      in   1   system clock
//   Reset_n       in   1   synchronous, active-low reset
//   Sample_Valid  in   1   Position/Velocity valid this cycle
//   Position      in  32   signed q8.24 ball position
//   Velocity      in  32   signed q8.24 ball velocity, positive = upward
//   Bounce_Pulse  out  1   one-cycle pulse per floor bounce
//   Apex_Pulse    out  1   one-cycle pulse at the top of a flight
//   Bounce_Count  out  8   floor bounces since reset, saturating
//   Peak_Height   out 32   max Position of the last completed flight
//   Flight_Steps  out 16   samples between the last two bounces, saturating
//   Resting       out  1   high while in REST
//   State         out  2   IDLE=0, ASCEND=1, DESCEND=2, REST=3
// ----------------------------------------------------------------------------
module bounce_monitor #(
  parameter logic signed [31:0] FLOOR_WINDOW     = 32'sh00010000,
  parameter logic        [15:0] MIN_FLIGHT_STEPS = 16'd64,
  parameter logic        [3:0]  REST_BOUNCES     = 4'd4,
  parameter logic signed [31:0] KICK_THRESH      = 32'sh01000000
) (
  input  logic               CLOCK_50,
  input  logic               Reset_n,
  input  logic               Sample_Valid,
  input  logic signed [31:0] Position,
  input  logic signed [31:0] Velocity,
  output logic               Bounce_Pulse,
  output logic               Apex_Pulse,
  output logic [7:0]         Bounce_Count,
  output logic signed [31:0] Peak_Height,
  output logic [15:0]        Flight_Steps,
  output logic               Resting,
  output logic [1:0]         State
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2,
    REST    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               bounce_pulse_q, bounce_pulse_d;
  logic               apex_pulse_q, apex_pulse_d;
  logic [7:0]         bounce_count_q, bounce_count_d;
  logic signed [31:0] peak_height_q, peak_height_d;
  logic [15:0]        flight_steps_q, flight_steps_d;
  logic               resting_q, resting_d;
  logic signed [31:0] run_max_q, run_max_d;
  logic [15:0]        step_cnt_q, step_cnt_d;
  logic [3:0]         short_cnt_q, short_cnt_d;

  // Shared per-sample terms.
  logic [15:0]        step_inc;
  logic signed [31:0] max_upd;
  logic               floor_rise;
  logic [3:0]         short_next;

  always_comb begin
    step_inc   = (step_cnt_q == 16'hFFFF) ? 16'hFFFF : step_cnt_q + 16'd1;
    max_upd    = (Position > run_max_q) ? Position : run_max_q;
    floor_rise = (Velocity > 32'sd0) && (Position <= FLOOR_WINDOW);
    // A flight's length is the step count including the bouncing sample,
    // which is exactly step_inc; a long flight breaks the short-hop streak.
    if (step_inc < MIN_FLIGHT_STEPS) begin
      short_next = (short_cnt_q == 4'hF) ? 4'hF : short_cnt_q + 4'd1;
    end else begin
      short_next = 4'd0;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    bounce_pulse_d = 1'b0;
    apex_pulse_d   = 1'b0;
    bounce_count_d = bounce_count_q;
    peak_height_d  = peak_height_q;
    flight_steps_d = flight_steps_q;
    run_max_d      = run_max_q;
    step_cnt_d     = step_cnt_q;
    short_cnt_d    = short_cnt_q;

    if (Sample_Valid) begin
      if (state_q != IDLE) begin
        step_cnt_d = step_inc;
        run_max_d  = max_upd;
      end

      // Bounce bookkeeping is identical in DESCEND and REST; only the
      // resulting state differs, which is decided in the case below.
      if (floor_rise && (state_q == DESCEND || state_q == REST)) begin
        bounce_pulse_d = 1'b1;
        bounce_count_d = (bounce_count_q == 8'hFF) ? 8'hFF
                                                   : bounce_count_q + 8'd1;
        peak_height_d  = max_upd;
        flight_steps_d = step_inc;
        step_cnt_d     = 16'd0;
        run_max_d      = Position;
        short_cnt_d    = short_next;
      end

      unique case (state_q)
        IDLE: begin
          state_d    = (Velocity > 32'sd0) ? ASCEND : DESCEND;
          run_max_d  = Position;
          step_cnt_d = 16'd0;
        end
        ASCEND: begin
          if (Velocity <= 32'sd0) begin
            apex_pulse_d = 1'b1;
            state_d      = DESCEND;
          end
        end
        DESCEND: begin
          if (floor_rise) begin
            state_d = (short_next >= REST_BOUNCES) ? REST : ASCEND;
          end else if (Velocity > 32'sd0) begin
            // Upward velocity well above the floor is a mid-air kick: the
            // flight continues, so counters and running max are kept.
            state_d = ASCEND;
          end
        end
        REST: begin
          // A strong upward kick restarts tracking from scratch; it wins
          // over any bounce bookkeeping done for the same sample.
          if (Velocity >= KICK_THRESH) begin
            state_d     = ASCEND;
            short_cnt_d = 4'd0;
            step_cnt_d  = 16'd0;
            run_max_d   = Position;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    resting_d = (state_d == REST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      bounce_pulse_q <= 1'b0;
      apex_pulse_q   <= 1'b0;
      bounce_count_q <= 8'd0;
      peak_height_q  <= 32'sd0;
      flight_steps_q <= 16'd0;
      resting_q      <= 1'b0;
      run_max_q      <= 32'sd0;
      step_cnt_q     <= 16'd0;
      short_cnt_q    <= 4'd0;
    end else begin
      state_q        <= state_d;
      bounce_pulse_q <= bounce_pulse_d;
      apex_pulse_q   <= apex_pulse_d;
      bounce_count_q <= bounce_count_d;
      peak_height_q  <= peak_height_d;
      flight_steps_q <= flight_steps_d;
      resting_q      <= resting_d;
      run_max_q      <= run_max_d;
      step_cnt_q     <= step_cnt_d;
      short_cnt_q    <= short_cnt_d;
    end
  end

  assign Bounce_Pulse = bounce_pulse_q;
  assign Apex_Pulse   = apex_pulse_q;
  assign Bounce_Count = bounce_count_q;
  assign Peak_Height  = peak_height_q;
  assign Flight_Steps = flight_steps_q;
  assign Resting      = resting_q;
  assign State        = state_q;

endmodule

// File: tb/tb_bounce_monitor.sv
// ----------------------------------------------------------------------------
// tb_bounce_monitor
//
// Directed, table-driven bench for bounce_monitor. Each table record holds a
// sample (applied for 'reps' consecutive cycles) and the outputs expected
// after the last of them. Hand-written sequences cover reset, saturation of
// the bounce and step counters, and reset in the middle of a flight.
// ----------------------------------------------------------------------------
module tb_bounce_monitor;

  localparam logic signed [31:0] NEG1  = 32'shFF000000;  // -1.0
  localparam logic signed [31:0] NEGS  = 32'shFFFD70A4;  // about -0.01
  localparam logic signed [31:0] UP75  = 32'sh00C00000;  // +0.75
  localparam logic signed [31:0] UP50  = 32'sh00800000;  // +0.5
  localparam logic signed [31:0] KICK3 = 32'sh03000000;  // +3.0

  logic               clk;
  logic               reset_n;
  logic               sample_valid;
  logic signed [31:0] position;
  logic signed [31:0] velocity;
  logic               bounce_pulse;
  logic               apex_pulse;
  logic [7:0]         bounce_count;
  logic signed [31:0] peak_height;
  logic [15:0]        flight_steps;
  logic               resting;
  logic [1:0]         state;

  int n_checks = 0;
  int n_pass   = 0;

  bounce_monitor dut (
    .CLOCK_50     (clk),
    .Reset_n      (reset_n),
    .Sample_Valid (sample_valid),
    .Position     (position),
    .Velocity     (velocity),
    .Bounce_Pulse (bounce_pulse),
    .Apex_Pulse   (apex_pulse),
    .Bounce_Count (bounce_count),
    .Peak_Height  (peak_height),
    .Flight_Steps (flight_steps),
    .Resting      (resting),
    .State        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                 reps;
    logic               valid;
    logic signed [31:0] pos;
    logic signed [31:0] vel;
    logic [1:0]         st;
    logic               bp;
    logic               ap;
    logic [7:0]         cnt;
    logic [31:0]        peak;
    logic [15:0]        fs;
    logic               rest;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int reps, input logic valid,
                              input logic [31:0] pos, input logic [31:0] vel,
                              input logic [1:0] st, input logic bp,
                              input logic ap, input logic [7:0] cnt,
                              input logic [31:0] peak, input logic [15:0] fs,
                              input logic rest);
    vec_t v;
    v.reps = reps; v.valid = valid; v.pos = pos; v.vel = vel;
    v.st = st; v.bp = bp; v.ap = ap; v.cnt = cnt;
    v.peak = peak; v.fs = fs; v.rest = rest;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st,
                           input logic bp, input logic ap,
                           input logic [7:0] cnt, input logic [31:0] peak,
                           input logic [15:0] fs, input logic rest);
    check({tag, ".state"},   {30'd0, state},         {30'd0, st});
    check({tag, ".bounce"},  {31'd0, bounce_pulse},  {31'd0, bp});
    check({tag, ".apex"},    {31'd0, apex_pulse},    {31'd0, ap});
    check({tag, ".count"},   {24'd0, bounce_count},  {24'd0, cnt});
    check({tag, ".peak"},    peak_height,            peak);
    check({tag, ".steps"},   {16'd0, flight_steps},  {16'd0, fs});
    check({tag, ".resting"}, {31'd0, resting},       {31'd0, rest});
  endtask

  // Drive one cycle of inputs and return #1 after the sampling edge.
  task automatic drive(input logic valid, input logic [31:0] pos,
                       input logic [31:0] vel);
    sample_valid = valid;
    position     = pos;
    velocity     = vel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    position     = 32'sd0;
    velocity     = 32'sd0;

    // Reset held for two edges with Sample_Valid toggling: outputs stay 0.
    for (int i = 0; i < 2; i++) begin
      drive(i[0], 32'sh04000000, KICK3);
      check_all($sformatf("reset%0d", i), 2'd0, 0, 0, 8'd0, 32'd0, 16'd0, 0);
    end
    reset_n = 1'b1;

    // reps valid pos vel | state bp ap cnt peak steps rest
    add(1,  1, 32'sh00000000, KICK3,         1, 0, 0, 0, 32'h0, 0, 0);
    add(9,  1, 32'sh02000000, 32'sh01000000, 1, 0, 0, 0, 32'h0, 0, 0);
    add(1,  1, 32'sh05000000, 32'sh01000000, 1, 0, 0, 0, 32'h0, 0, 0);
    add(1,  1, 32'sh04FF0000, NEGS,          2, 0, 1, 0, 32'h0, 0, 0);
    add(1,  0, 32'sh00000000, KICK3,         2, 0, 0, 0, 32'h0, 0, 0);
    add(51, 1, 32'sh02000000, NEG1,          2, 0, 0, 0, 32'h0, 0, 0);
    add(1,  1, 32'sh00000100, NEG1,          2, 0, 0, 0, 32'h0, 0, 0);
    // First bounce: 65th sample since reset, 64 samples after the first.
    add(1,  1, 32'sh00000100, UP75,          1, 1, 0, 1, 32'h05000000, 64, 0);
    add(1,  0, 32'sh00000000, UP75,          1, 0, 0, 1, 32'h05000000, 64, 0);
    add(1,  1, 32'sh03000000, NEG1,          2, 0, 1, 1, 32'h05000000, 64, 0);
    // Mid-air kick above the floor window: back to ASCEND, nothing counted.
    add(1,  1, 32'sh02000000, UP50,          1, 0, 0, 1, 32'h05000000, 64, 0);
    add(1,  1, 32'sh01000000, NEG1,          2, 0, 1, 1, 32'h05000000, 64, 0);
    add(6,  1, 32'sh00800000, NEG1,          2, 0, 0, 1, 32'h05000000, 64, 0);
    add(1,  1, 32'sh00000000, UP75,          1, 1, 0, 2, 32'h03000000, 10, 0);
    // Three more 10-sample flights; the last of four short ones enters REST.
    // Bounces land at 0, exactly on FLOOR_WINDOW, and at a negative height.
    for (int k = 3; k <= 5; k++) begin
      logic [31:0] prev_peak;
      logic [31:0] bpos;
      prev_peak = (k == 3) ? 32'h03000000 : 32'h00500000;
      bpos = (k == 3) ? 32'h00000000 : (k == 4) ? 32'h00010000 : 32'hFFF00000;
      add(1, 1, 32'sh00400000, 32'sh00400000, 1, 0, 0, 8'(k - 1), prev_peak, 10, 0);
      add(1, 1, 32'sh00500000, NEG1,          2, 0, 1, 8'(k - 1), prev_peak, 10, 0);
      add(7, 1, 32'sh00100000, NEG1,          2, 0, 0, 8'(k - 1), prev_peak, 10, 0);
      add(1, 1, bpos,          UP75, (k == 5) ? 2'd3 : 2'd1, 1, 0, 8'(k),
          32'h00500000, 10, (k == 5));
    end
    add(1,  0, 32'sh00000000, KICK3,         3, 0, 0, 5, 32'h00500000, 10, 1);
    // Kick out of REST.
    add(1,  1, 32'sh00200000, KICK3,         1, 0, 0, 5, 32'h00500000, 10, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i].valid, vecs[i].pos, vecs[i].vel);
      end
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].bp, vecs[i].ap,
                vecs[i].cnt, vecs[i].peak, vecs[i].fs, vecs[i].rest);
    end

    // 300 two-sample bounces: short hops drop into REST, count saturates.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'sh00000100, NEG1);
      drive(1'b1, 32'sh00000000, UP50);
      if (i == 244) begin
        check("sat.count250", {24'd0, bounce_count}, 32'd250);
        check("sat.state250", {30'd0, state}, 32'd3);
      end
    end
    check_all("sat300", 2'd3, 1, 0, 8'd255, 32'h00000100, 16'd2, 1);

    // Kick out, then a 70000-sample flight: Flight_Steps saturates.
    drive(1'b1, 32'sh00200000, KICK3);
    check_all("kick2", 2'd1, 0, 0, 8'd255, 32'h00000100, 16'd2, 0);
    drive(1'b1, 32'sh00200000, NEG1);
    check_all("apex2", 2'd2, 0, 1, 8'd255, 32'h00000100, 16'd2, 0);
    for (int i = 0; i < 69998; i++) begin
      drive(1'b1, 32'sh00100000, NEG1);
    end
    drive(1'b1, 32'sh00000000, UP50);
    check_all("long", 2'd1, 1, 0, 8'd255, 32'h00200000, 16'hFFFF, 0);

    // Reset in mid-flight clears everything on the next cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'sh01000000, 32'sh01000000);
    end
    reset_n = 1'b0;
    drive(1'b1, 32'sh01000000, 32'sh01000000);
    check_all("midrst", 2'd0, 0, 0, 8'd0, 32'd0, 16'd0, 0);
    reset_n = 1'b1;
    drive(1'b1, 32'sh00800000, NEG1);
    check_all("post1", 2'd2, 0, 0, 8'd0, 32'd0, 16'd0, 0);
    drive(1'b1, 32'sh00000000, UP50);
    check_all("post2", 2'd1, 1, 0, 8'd1, 32'h00800000, 16'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bounce_monitor.md
Name: bounce_monitor

Overview:
- Reads the ball position/velocity stream produced by the bouncing-ball physics core, one sample per time step, and reconstructs flight events from it.
- Reports floor bounces, apex events, peak height of the last completed flight, flight duration in time steps, and a "resting" flag.
- Outputs drive the HEX and debug displays and give the bench a second, independent observer of the physics core.
- Data format: signed q8.24 (sign bit, 7 integer bits, 24 fractional bits).

Parameters:
- FLOOR_WINDOW, 32'sh00010000, position at or below which a velocity sign flip from negative to positive counts as a floor bounce
- MIN_FLIGHT_STEPS, 16'd64, flights shorter than this (in samples) count as "short"
- REST_BOUNCES, 4'd4, consecutive short flights that put the block into REST
- KICK_THRESH, 32'sh01000000, velocity at or above which REST is exited

Ports:
- CLOCK_50  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- Sample_Valid  in  1  one-cycle strobe; Position/Velocity valid this cycle
- Position  in  32  signed q8.24 ball position
- Velocity  in  32  signed q8.24 ball velocity, positive = upward
- Bounce_Pulse  out  1  one-cycle pulse per detected floor bounce
- Apex_Pulse  out  1  one-cycle pulse when the ball passes the top of a flight
- Bounce_Count  out  8  floor bounces since reset, saturating
- Peak_Height  out  32  maximum Position seen during the last completed flight
- Flight_Steps  out  16  samples between the last two bounces, saturating
- Resting  out  1  high while in REST
- State  out  2  IDLE=0, ASCEND=1, DESCEND=2, REST=3

Behaviour:

Clock and reset
- Single clock, CLOCK_50.
- Reset is synchronous, active-low: Reset_n low at a CLOCK_50 edge forces State=IDLE and all outputs to 0.
- Internal running max, step counter and short-flight counter also clear to 0.
- Reset mid-flight discards all partial flight data; there is no recovery of pre-reset data.

Sampling and latency
- Inputs are sampled only on cycles where Sample_Valid=1; all other cycles hold state.
- Every output is registered and updates on the edge that samples Sample_Valid, so it is visible the following cycle.
- Pulses are high for exactly one cycle.

Per-sample bookkeeping (all non-IDLE states)
- Step counter increments and saturates at 16'hFFFF.
- Running max = max(running max, Position), signed compare.

IDLE
- First valid sample: go to ASCEND if Velocity>0, else DESCEND.
- Running max = Position; step counter = 0.
- No pulse is emitted.

ASCEND
- Velocity<=0: assert Apex_Pulse, go to DESCEND.

DESCEND
- Velocity>0 and Position<=FLOOR_WINDOW is a bounce:
  - Assert Bounce_Pulse.
  - Bounce_Count increments, saturating at 255.
  - Peak_Height = running max, including the current sample.
  - Flight_Steps = step counter + 1, saturating.
  - Step counter = 0; running max = Position.
  - Short flight (new Flight_Steps < MIN_FLIGHT_STEPS): short counter increments. Otherwise the short counter clears.
  - Short counter reaches REST_BOUNCES: go to REST. Otherwise go to ASCEND.
- Velocity>0 and Position>FLOOR_WINDOW (mid-air kick):
  - Go to ASCEND.
  - No pulse, no counter change, running max kept.

REST
- Resting=1.
- Bounces are still counted, with Bounce_Pulse and Peak_Height/Flight_Steps updated as above, but the state stays REST.
- Velocity>=KICK_THRESH:
  - Go to ASCEND.
  - Short counter = 0, step counter = 0, running max = Position.
  - Resting drops on the same update.

Arithmetic and widths
- All Position/Velocity compares are signed 32-bit.
- Negative Position is legal and is treated as within the floor window.

Test Plan:
1. Reset_n=0 for 2 cycles, Sample_Valid toggling -> all outputs 0 and State=0 throughout; first sample after release with Velocity=32'sh03000000 -> State=1, no pulse.
2. Ascend at Velocity=+1.0 for 10 samples with Position rising to 32'sh05000000, then Velocity=-0.01 -> Apex_Pulse high exactly 1 cycle, State=2.
3. Descend to Position=32'sh00000100, then Velocity=+0.75 -> Bounce_Pulse 1 cycle, Bounce_Count=1, Peak_Height=32'sh05000000, Flight_Steps equal to the sample count since the first sample after reset.
4. Velocity flips positive with Position=32'sh02000000 -> State=1, Bounce_Count unchanged, no pulses.
5. Four consecutive bounces with flights of 10 samples each -> Resting=1 and State=3 after the 4th; then a sample with Velocity=32'sh03000000 -> State=1, Resting=0.
6. 300 bounces -> Bounce_Count holds 255; a 70000-sample flight -> Flight_Steps=16'hFFFF; Reset_n=0 mid-flight -> all outputs 0 on the next cycle.
